rx_frame_ctrl: RTL and testbench

- Sequences the byte stream from the RGMII receive demultiplexer (byte data plus a payload-active flag, valid at posedge of the recovered rx clock) into a single-frame receive buffer.
- Filters on destination MAC, enforces length limits, checks buffer availability and optionally FCS, then commits or discards each frame.
- Sits between the RGMII receive front end and the UDP/IP parser; all logic runs on the recovered rx clock.

---
 rtl/eth_rx_pkg.sv | 25 ++
 rtl/crc32_d8.sv | 24 ++
 rtl/rx_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the receive frame controller.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DST     = 3'd1,
    S_BODY    = 3'd2,
    S_DISCARD = 3'd3,
    S_CHECK   = 3'd4
  } rx_state_t;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Register value left after the whole frame, FCS included, has been shifted in.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_LEN       = 4;

  // Bit-reverse a 32-bit word; the CRC runs LSB-first, so it uses the mirrored polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next state for one byte, reflected (LSB-first) form.
// Only instantiated when RX_FCS_CHECK_EN is defined.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] c;

  // Eight serial LSB-first shift steps unrolled into one cycle.
  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: writes one frame into the buffer, filters on
// destination MAC and length, then commits or drops it.
// Optional FCS check: define RX_FCS_CHECK_EN.
//
// state     | meaning
// S_IDLE    | waiting for rx_active to rise (armed only after rx_active seen low)
// S_DST     | bytes 1-6, destination MAC compare, all bytes written
// S_BODY    | remaining bytes written at address = byte index
// S_DISCARD | frame rejected, bytes counted but not written
// S_CHECK   | one-cycle accept/reject decision, commit or drop pulse
module rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64,
  parameter int ADDR_W    = 11,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_active,
  input  logic [47:0]       local_mac,
  input  logic              buf_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              commit,
  output logic [ADDR_W:0]   commit_len,
  output logic              drop,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_drop
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAME);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME);

  rx_state_t     state;
  logic          rx_active_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          mac_ok;
  logic          bc_ok;
  logic          force_drop;
  logic [7:0]    mac_byte;
  logic          mac_hit;
  logic          bc_hit;
  logic          fcs_ok;
  logic          accept;

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_next;

  // A new frame restarts the CRC from all-ones.
  crc32_d8 u_crc (
    .crc_in  ((state == S_IDLE) ? 32'hFFFF_FFFF : crc),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  assign fcs_ok = (crc == CRC32_RESIDUE);
`else
  assign fcs_ok = 1'b1;
`endif

  assign count_inc = (count == '1) ? count : count + 1'b1;
  assign accept    = !force_drop && (count >= MIN_C) && (count <= MAX_C) && fcs_ok;

  // Select the local MAC byte for the current destination byte, MSB first.
  always_comb begin
    mac_byte = local_mac[47:40];
    if (state != S_IDLE) begin
      case (count[2:0])
        3'd1:    mac_byte = local_mac[39:32];
        3'd2:    mac_byte = local_mac[31:24];
        3'd3:    mac_byte = local_mac[23:16];
        3'd4:    mac_byte = local_mac[15:8];
        3'd5:    mac_byte = local_mac[7:0];
        default: mac_byte = local_mac[47:40];
      endcase
    end
    mac_hit = (rx_data == mac_byte) && ((state == S_IDLE) || mac_ok);
    bc_hit  = (rx_data == BROADCAST_MAC[7:0]) && ((state == S_IDLE) || bc_ok);
  end

  // Frame sequencing, registered buffer writes, result pulses and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rx_active_q <= 1'b1;
      count       <= '0;
      mac_ok      <= 1'b0;
      bc_ok       <= 1'b0;
      force_drop  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit      <= 1'b0;
      commit_len  <= '0;
      drop        <= 1'b0;
      frames_ok   <= '0;
      frames_drop <= '0;
`ifdef RX_FCS_CHECK_EN
      crc         <= '1;
`endif
    end else begin
      rx_active_q <= rx_active;
      wr_en       <= 1'b0;
      commit      <= 1'b0;
      drop        <= 1'b0;
      commit_len  <= '0;
      case (state)
        S_IDLE: begin
          if (rx_active && !rx_active_q) begin
            count      <= CW'(1);
            force_drop <= 1'b0;
            if (buf_ready) begin
              state   <= S_DST;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= rx_data;
              mac_ok  <= mac_hit;
              bc_ok   <= bc_hit;
`ifdef RX_FCS_CHECK_EN
              crc     <= crc_next;
`endif
            end else begin
              state <= S_DISCARD;
            end
          end
        end
        S_DST: begin
          if (!rx_active) begin
            state      <= S_CHECK;
            force_drop <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= rx_data;
            count   <= count_inc;
            mac_ok  <= mac_hit;
            bc_ok   <= bc_hit;
`ifdef RX_FCS_CHECK_EN
            crc     <= crc_next;
`endif
            if (count == CW'(5)) state <= (mac_hit || bc_hit) ? S_BODY : S_DISCARD;
          end
        end
        S_BODY: begin
          if (!rx_active) begin
            state <= S_CHECK;
          end else if (count == MAX_C) begin
            // The byte that would exceed MAX_FRAME is not written.
            state      <= S_DISCARD;
            force_drop <= 1'b1;
            count      <= count_inc;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= rx_data;
            count   <= count_inc;
`ifdef RX_FCS_CHECK_EN
            crc     <= crc_next;
`endif
          end
        end
        S_DISCARD: begin
          if (!rx_active) begin
            state      <= S_CHECK;
            force_drop <= 1'b1;
          end else begin
            count <= count_inc;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (accept) begin
            commit     <= 1'b1;
            commit_len <= count - CW'(FCS_LEN);
            if (frames_ok != '1) frames_ok <= frames_ok + 1'b1;
          end else begin
            drop <= 1'b1;
            if (frames_drop != '1) frames_drop <= frames_drop + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl. Frames are built with a real
// Ethernet FCS; expectations come from the frame-level acceptance rules.
module tb_rx_frame_ctrl;

  localparam int MAXF = 1518;
  localparam int MINF = 64;
  localparam logic [47:0] LMAC  = 48'h001C_C0A2_1234;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_active = 1'b0;
  logic [47:0] local_mac = LMAC;
  logic        buf_ready = 1'b1;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic [11:0] commit_len;
  logic        drop;
  logic [7:0]  frames_ok;
  logic [7:0]  frames_drop;

  rx_frame_ctrl #(.MAX_FRAME(MAXF), .MIN_FRAME(MINF), .ADDR_W(11), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
    .local_mac(local_mac), .buf_ready(buf_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .commit_len(commit_len), .drop(drop),
    .frames_ok(frames_ok), .frames_drop(frames_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          c;
    bit          d;
    int          stamp;
    logic [11:0] len;
  } ev_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          poscount = 0;
  int          zero_p = 0;
  int          m_ok = 0;
  int          m_drop = 0;
  logic [18:0] wr_q[$];
  ev_t         ev_q[$];

  always @(posedge clock) poscount <= poscount + 1;

  // Monitor: collect buffer writes and result pulses, sampled mid-cycle.
  always @(negedge clock) begin
    ev_t e;
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (commit || drop) begin
      e.c = commit; e.d = drop; e.stamp = poscount; e.len = commit_len;
      ev_q.push_back(e);
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input int len, input bit bad,
                             output logic [7:0] fr[$]);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) fr.push_back(dst[8*(5-i) +: 8]);
      else fr.push_back(8'($urandom));
    end
    if (len >= 10) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < len - 4; i++) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) fr[len-4+k] = c[8*k +: 8];
      if (bad) fr[len-1-$urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
    end
  endtask

  // Frame-level reference: how many bytes land in the buffer and whether it is accepted.
  task automatic model(input logic [7:0] fr[$], input bit buf_ok, output int nwr, output bit acc);
    int          len;
    logic [47:0] dst;
    logic [31:0] c;
    bit          dst_ok, fcs_good;
    len = fr.size();
    dst = '0;
    for (int i = 0; i < 6 && i < len; i++) dst[8*(5-i) +: 8] = fr[i];
    dst_ok = (len >= 6) && (dst == LMAC || dst == BCAST);
    fcs_good = 1'b0;
    if (len >= 10) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < len - 4; i++) c = crc_upd(c, fr[i]);
      c = ~c;
      fcs_good = ({fr[len-1], fr[len-2], fr[len-3], fr[len-4]} == c);
    end
`ifndef RX_FCS_CHECK_EN
    fcs_good = 1'b1;
`endif
    if (!buf_ok) nwr = 0;
    else if (len < 6) nwr = len;
    else if (!dst_ok) nwr = 6;
    else nwr = (len < MAXF) ? len : MAXF;
    acc = buf_ok && dst_ok && len >= MINF && len <= MAXF && fcs_good;
    if (acc) m_ok = (m_ok < 255) ? m_ok + 1 : 255;
    else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
  endtask

  function automatic int wr_errors(input logic [7:0] fr[$]);
    int errs = 0;
    for (int j = 0; j < wr_q.size(); j++) begin
      if (wr_q[j][18:8] != 11'(j)) errs++;
      else if (j >= fr.size()) errs++;
      else if (wr_q[j][7:0] != fr[j]) errs++;
    end
    return errs;
  endfunction

  // Drive one frame then an 8-cycle gap; flip_at raises buf_ready mid-frame, reset_at pulses reset.
  task automatic run_frame(input logic [7:0] fr[$], input bit buf0, input int flip_at, input int reset_at);
    wr_q.delete();
    ev_q.delete();
    for (int i = 0; i < fr.size(); i++) begin
      @(negedge clock);
      rx_active = 1'b1;
      rx_data   = fr[i];
      buf_ready = (flip_at >= 0 && i >= flip_at) ? 1'b1 : buf0;
      reset     = (i == reset_at);
    end
    @(negedge clock);
    rx_active = 1'b0;
    reset     = 1'b0;
    rx_data   = 8'($urandom);
    zero_p    = poscount;
    repeat (7) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_active = 1'b1;
    repeat (3) begin @(negedge clock); rx_data = 8'($urandom); end
    n_cmp++;
    if ({wr_en, commit, drop} !== 3'b000)
      $display("FAIL reset_strobes: got %b required 000", {wr_en, commit, drop});
    n_cmp++;
    if ({frames_ok, frames_drop} !== 16'h0)
      $display("FAIL reset_counters: got ok=%0d drop=%0d required 0/0", frames_ok, frames_drop);
    n_cmp++;
    if ({wr_addr, wr_data, commit_len} !== 31'h0)
      $display("FAIL reset_data: got addr=%0d data=%0h len=%0d required 0", wr_addr, wr_data, commit_len);
    if ({wr_en, commit, drop} !== 3'b000 || {frames_ok, frames_drop} !== 16'h0 ||
        {wr_addr, wr_data, commit_len} !== 31'h0) n_fail++;
    // Release reset while a frame is in flight: it must be ignored entirely.
    wr_q.delete(); ev_q.delete();
    reset = 1'b0;
    repeat (12) begin @(negedge clock); rx_data = 8'($urandom); end
    rx_active = 1'b0;
    repeat (8) @(negedge clock);
    n_cmp++;
    if (wr_q.size() !== 0 || ev_q.size() !== 0) begin
      n_fail++;
      $display("FAIL post_reset_wait: got writes=%0d events=%0d required 0/0", wr_q.size(), ev_q.size());
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] fr[$], input bit buf0, input int flip_at);
    int nwr, errs;
    bit acc;
    run_frame(fr, buf0, flip_at, -1);
    model(fr, buf0, nwr, acc);
    n_cmp++;
    if (wr_q.size() !== nwr) begin
      n_fail++; $display("FAIL %s writes: got %0d required %0d", name, wr_q.size(), nwr);
    end
    errs = wr_errors(fr);
    n_cmp++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL %s write_content: got %0d bad writes required 0", name, errs);
    end
    n_cmp++;
    if (ev_q.size() !== 1) begin
      n_fail++; $display("FAIL %s pulses: got %0d required 1", name, ev_q.size());
    end else begin
      n_cmp++;
      if (ev_q[0].c !== acc || ev_q[0].d !== !acc) begin
        n_fail++; $display("FAIL %s verdict: got commit=%0b drop=%0b required commit=%0b", name, ev_q[0].c, ev_q[0].d, acc);
      end
      n_cmp++;
      if (ev_q[0].stamp !== zero_p + 2) begin
        n_fail++; $display("FAIL %s timing: got edge %0d required %0d", name, ev_q[0].stamp, zero_p + 2);
      end
      if (acc) begin
        n_cmp++;
        if (ev_q[0].len !== 12'(fr.size() - 4)) begin
          n_fail++; $display("FAIL %s commit_len: got %0d required %0d", name, ev_q[0].len, fr.size() - 4);
        end
      end
    end
    n_cmp++;
    if (frames_ok !== 8'(m_ok) || frames_drop !== 8'(m_drop)) begin
      n_fail++; $display("FAIL %s counters: got ok=%0d drop=%0d required %0d/%0d", name, frames_ok, frames_drop, m_ok, m_drop);
    end
  endtask

  task automatic test_frames();
    logic [7:0] fr[$];
    build_frame(LMAC, 64, 0, fr);                     check_frame("unicast64", fr, 1, -1);
    build_frame(BCAST, 100, 0, fr);                   check_frame("bcast100", fr, 1, -1);
    build_frame(48'h001C_C0A2_1235, 64, 0, fr);       check_frame("mac_miss", fr, 1, -1);
    build_frame(LMAC, 64, 0, fr);                     check_frame("buf_busy", fr, 0, 10);
    build_frame(LMAC, 40, 0, fr);                     check_frame("runt40", fr, 1, -1);
    build_frame(LMAC, 63, 0, fr);                     check_frame("len63", fr, 1, -1);
    build_frame(LMAC, 1518, 0, fr);                   check_frame("len1518", fr, 1, -1);
    build_frame(LMAC, 1519, 0, fr);                   check_frame("len1519", fr, 1, -1);
    build_frame(LMAC, 64, 1, fr);                     check_frame("bad_fcs", fr, 1, -1);
    build_frame(LMAC, 4, 0, fr);                      check_frame("short4", fr, 1, -1);
  endtask

  task automatic test_random();
    logic [7:0]  fr[$];
    logic [47:0] dst;
    int          sel;
    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? LMAC : (sel == 1) ? BCAST : (LMAC ^ (48'h1 << $urandom_range(0, 47)));
      build_frame(dst, $urandom_range(20, 200), ($urandom_range(0, 3) == 0), fr);
      check_frame("random", fr, ($urandom_range(0, 4) != 0), -1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] fr[$];
    build_frame(LMAC, 64, 0, fr);
    run_frame(fr, 1, -1, 19);
    m_ok = 0; m_drop = 0;
    n_cmp++;
    if (ev_q.size() !== 0) begin
      n_fail++; $display("FAIL reset_mid pulses: got %0d required 0", ev_q.size());
    end
    n_cmp++;
    if (wr_q.size() !== 19) begin
      n_fail++; $display("FAIL reset_mid writes: got %0d required 19", wr_q.size());
    end
    n_cmp++;
    if (frames_ok !== 8'd0 || frames_drop !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid counters: got ok=%0d drop=%0d required 0/0", frames_ok, frames_drop);
    end
    build_frame(LMAC, 64, 0, fr);
    check_frame("after_reset", fr, 1, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr[$];
    int nwr;
    bit acc;
    for (int n = 0; n < 300; n++) begin
      build_frame(LMAC, 64, 0, fr);
      run_frame(fr, 1, -1, -1);
      model(fr, 1, nwr, acc);
      n_cmp++;
      if (ev_q.size() !== 1 || !acc || ev_q[0].c !== 1'b1 || ev_q[0].d !== 1'b0) begin
        n_fail++; $display("FAIL b2b frame %0d: got %0d pulses required one commit", n, ev_q.size());
      end
      n_cmp++;
      if (frames_ok !== 8'(m_ok)) begin
        n_fail++; $display("FAIL b2b frames_ok frame %0d: got %0d required %0d", n, frames_ok, m_ok);
      end
    end
    n_cmp++;
    if (frames_ok !== 8'd255) begin
      n_fail++; $display("FAIL b2b saturation: got %0d required 255", frames_ok);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
